alu_registered: RTL and testbench
=================================

ALU_REGISTERED -- requirements
Module: alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand and result width in bits; all values below assume WIDTH=64.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clk.
REQ-004 control  input  2  operation select: 00 add, 01 subtract, 10 bitwise AND, 11 bitwise XOR.
REQ-005 X  input  WIDTH  first operand, two's-complement signed.
REQ-006 Y  input  WIDTH  second operand, two's-complement signed.
REQ-007 Z  output  WIDTH  registered result.
REQ-008 ovf  output  1  registered signed-overflow flag for the result in Z.

Function
REQ-009 The block SHALL compute the operation combinationally from control, X and Y, and capture the result into the Z and ovf registers on every rising clk edge where reset is low.
REQ-010 Latency SHALL be exactly one cycle: inputs present at edge N appear on Z/ovf after edge N and hold until edge N+1.
REQ-011 No handshake; a new operation SHALL be accepted every cycle (throughput 1/cycle).
REQ-012 control=00: Z SHALL equal (X + Y) mod 2^WIDTH.
REQ-013 control=01: Z SHALL equal (X - Y) mod 2^WIDTH, i.e. X + ~Y + 1; operand order is X minus Y.
REQ-014 control=10: Z SHALL equal X & Y, bitwise.
REQ-015 control=11: Z SHALL equal X ^ Y, bitwise.
REQ-016 Add overflow: ovf SHALL be 1 iff X[MSB]==Y[MSB] and Z[MSB]!=X[MSB].
REQ-017 Subtract overflow: ovf SHALL be 1 iff X[MSB]!=Y[MSB] and Z[MSB]!=X[MSB].
REQ-018 For AND and XOR, ovf SHALL be 0.
REQ-019 Unsigned carry-out SHALL NOT affect ovf (e.g. -1 + 1 = 0 with ovf=0).
REQ-020 Results SHALL wrap modulo 2^WIDTH; no saturation.
REQ-021 X or Y containing X/Z bits is outside the supported operating range; no output requirement applies.

Reset
REQ-022 When reset is high at a rising clk edge, Z SHALL become 0 and ovf SHALL become 0, regardless of control, X, Y.
REQ-023 Reset SHALL take priority over any operation presented in the same cycle; the discarded operation is not replayed.
REQ-024 Reset asserted mid-stream SHALL not corrupt later results: the first edge with reset low SHALL register the operation presented at that edge.
REQ-025 Before the first reset, Z/ovf values are undefined; the bench SHALL apply reset for at least one edge first.

Verification
REQ-026 control=00, X=63, Y=1 -> Z=64, ovf=0 one cycle later.
REQ-027 control=01, X=0x7FFF_FFFF_FFFF_FFFF, Y=-7000000000 -> Z=0x8000_0001_A13B_85FF, ovf=1.
REQ-028 control=10, X=0xAAAA_AAAA_AAAA_AAAB, Y=0x5555_5555_5555_5555 -> Z=0x0000_0000_0000_0001, ovf=0; same operands with control=11 -> Z=0xFFFF_FFFF_FFFF_FFFE, ovf=0.
REQ-029 control=00, X=Y=0x7FFF_FFFF_FFFF_FFFF -> Z=0xFFFF_FFFF_FFFF_FFFE, ovf=1; control=01, X=0x8000_0000_0000_0000, Y=1 -> Z=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
REQ-030 control=00, X=-1, Y=1 -> Z=0, ovf=0 (carry out ignored); control=01, X=5, Y=5 -> Z=0, ovf=0.
REQ-031 Back-to-back ops on consecutive edges with reset asserted for one edge in the middle -> Z=0, ovf=0 for that cycle, then correct results resume on the next edge.

Source files
------------

// File: rtl/alu_registered.sv
// Registered two-operand ALU: add, subtract, AND, XOR with a signed-overflow flag.
// Result and flag are captured one cycle after the operands are presented.
module alu_registered #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic             ovf
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_t;

  op_t              op;
  logic [WIDTH-1:0] y_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] result;
  logic             ovf_next;

  assign op = op_t'(control);

  // Subtraction reuses the adder: X + ~Y + 1, carry-in supplied by the literal 1.
  always_comb begin
    y_eff = (op == OP_SUB) ? ~Y : Y;
    sum   = X + y_eff + {{(WIDTH-1){1'b0}}, (op == OP_SUB)};
  end

  always_comb begin
    result   = '0;
    ovf_next = 1'b0;
    unique case (op)
      OP_ADD: begin
        result   = sum;
        ovf_next = (X[MSB] == Y[MSB]) && (sum[MSB] != X[MSB]);
      end
      OP_SUB: begin
        result   = sum;
        ovf_next = (X[MSB] != Y[MSB]) && (sum[MSB] != X[MSB]);
      end
      OP_AND: result = X & Y;
      OP_XOR: result = X ^ Y;
      default: begin
        result   = '0;
        ovf_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Z   <= '0;
      ovf <= 1'b0;
    end else begin
      Z   <= result;
      ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_alu_registered.sv
// Directed and random checks of alu_registered through an expected-result queue,
// including overflow corners and a reset pulse in the middle of back-to-back ops.
module tb_alu_registered;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  control;
  logic [63:0] X;
  logic [63:0] Y;
  logic [63:0] Z;
  logic        ovf;

  int tests  = 0;
  int failed = 0;

  logic [64:0] exp_q[$];
  string       tag_q[$];

  alu_registered #(.WIDTH(64)) dut (
    .clk     (clk),
    .reset   (reset),
    .control (control),
    .X       (X),
    .Y       (Y),
    .Z       (Z),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: overflow taken from a sign-extended 65-bit result.
  function automatic logic [64:0] model(input logic [1:0] c, input logic [63:0] x,
                                        input logic [63:0] y);
    logic signed [64:0] w;
    logic [63:0]        z;
    logic               o;
    w = '0;
    z = '0;
    o = 1'b0;
    case (c)
      2'b00: begin
        w = $signed({x[63], x}) + $signed({y[63], y});
        z = w[63:0];
        o = w[64] ^ w[63];
      end
      2'b01: begin
        w = $signed({x[63], x}) - $signed({y[63], y});
        z = w[63:0];
        o = w[64] ^ w[63];
      end
      2'b10: z = x & y;
      default: z = x ^ y;
    endcase
    return {z, o};
  endfunction

  task automatic check_out();
    logic [64:0] e;
    string       t;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL empty_queue observed Z=%h ovf=%b expected=<entry>", Z, ovf);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (Z === e[64:1]) else begin
      failed++;
      $error("FAIL %s Z observed=%h expected=%h", t, Z, e[64:1]);
    end
    tests++;
    assert (ovf === e[0]) else begin
      failed++;
      $error("FAIL %s ovf observed=%b expected=%b", t, ovf, e[0]);
    end
  endtask

  task automatic step(input logic rst, input logic [1:0] c, input logic [63:0] x,
                      input logic [63:0] y, input logic [63:0] ez, input logic eo,
                      input string tag);
    @(negedge clk);
    reset   = rst;
    control = c;
    X       = x;
    Y       = y;
    exp_q.push_back({ez, eo});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic step_model(input logic [1:0] c, input logic [63:0] x,
                            input logic [63:0] y, input string tag);
    logic [64:0] m;
    m = model(c, x, y);
    step(1'b0, c, x, y, m[64:1], m[0], tag);
  endtask

  initial begin
    reset   = 1'b1;
    control = 2'b00;
    X       = '0;
    Y       = '0;

    step(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, "reset_init");
    step(1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1'b0, "reset_hold");

    step(1'b0, 2'b00, 64'd63, 64'd1, 64'd64, 1'b0, "add_63_1");
    step(1'b0, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, -64'sd7000000000,
         64'h8000_0001_A13B_85FF, 1'b1, "sub_ovf_big");
    step(1'b0, 2'b10, 64'hAAAA_AAAA_AAAA_AAAB, 64'h5555_5555_5555_5555,
         64'h0000_0000_0000_0001, 1'b0, "and_pattern");
    step(1'b0, 2'b11, 64'hAAAA_AAAA_AAAA_AAAB, 64'h5555_5555_5555_5555,
         64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "xor_pattern");
    step(1'b0, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
         64'hFFFF_FFFF_FFFF_FFFE, 1'b1, "add_pos_ovf");
    step(1'b0, 2'b01, 64'h8000_0000_0000_0000, 64'd1,
         64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "sub_neg_ovf");
    step(1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b0, "add_carry_ignored");
    step(1'b0, 2'b01, 64'd5, 64'd5, 64'h0, 1'b0, "sub_equal");
    step(1'b0, 2'b01, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "sub_wrap_neg1");
    step(1'b0, 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
         64'h0, 1'b1, "add_neg_ovf");
    step(1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
         64'h8000_0000_0000_0000, 1'b0, "and_no_ovf");

    // Back-to-back with a single reset edge in the middle.
    step(1'b0, 2'b00, 64'd100, 64'd23, 64'd123, 1'b0, "b2b_before");
    step(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 1'b0, "b2b_reset");
    step(1'b0, 2'b01, 64'd10, 64'd3, 64'd7, 1'b0, "b2b_after");
    step(1'b0, 2'b11, 64'h0F0F, 64'h00FF, 64'h0FF0, 1'b0, "b2b_after2");

    for (int i = 0; i < 40; i++) begin
      logic [63:0] rx;
      logic [63:0] ry;
      logic [1:0]  rc;
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom};
      rc = 2'($urandom_range(3, 0));
      if (i % 8 == 0) begin
        rx[63:60] = 4'h7;
        ry[63:60] = (rc == 2'b01) ? 4'h8 : 4'h7;
      end
      step_model(rc, rx, ry, $sformatf("rand_%0d_op%0d", i, rc));
    end

    tests++;
    assert (exp_q.size() == 0) else begin
      failed++;
      $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
